step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter DEPTH, default 249, SHALL set the transducer count streamed per burst.
REQ-002 Parameter GUARD, default 8, SHALL set the idle cycles after a burst, covering divider latency 6 plus 2.
REQ-003 Parameters DEFAULT_STEPS_INTENSITY, default 10, and DEFAULT_STEPS_PHASE, default 40, SHALL set the completion-step reset values.
REQ-004 Ports SHALL be, in this order:
- CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- UPDATE  in  1  burst request pulse.
- CONFIG_VALID  in  1  new completion steps valid.
- CONFIG_STEPS_INTENSITY  in  8  requested intensity steps.
- CONFIG_STEPS_PHASE  in  8  requested phase steps.
- SRC_ADDR  out  8  source memory read address; data returns 1 cycle later.
- SRC_INTENSITY  in  8  source intensity.
- SRC_PHASE  in  8  source phase.
- DOUT_VALID  out  1  drives step calculator DIN_VALID.
- INTENSITY  out  8  streamed intensity.
- PHASE  out  8  streamed phase.
- COMPLETION_STEPS_INTENSITY  out  8  divisor for the intensity path.
- COMPLETION_STEPS_PHASE  out  8  divisor for the phase path.
- BUSY  out  1  high whenever state is not IDLE.
- OVERRUN  out  1  one-cycle pulse when UPDATE is dropped.
- OVERRUN_COUNT  out  16  saturating count of dropped UPDATEs.

Function
REQ-005 The FSM SHALL have states IDLE, FETCH, STREAM and GUARD_WAIT.
REQ-006 IDLE with UPDATE high SHALL go to FETCH next edge, with SRC_ADDR=0.
REQ-007 FETCH SHALL last 1 cycle, then STREAM, with SRC_ADDR incrementing each cycle.
REQ-008 STREAM SHALL assert DOUT_VALID for exactly DEPTH contiguous cycles, presenting INTENSITY/PHASE of addresses 0..DEPTH-1 in order, registered from SRC_* (no gaps permitted).
REQ-009 SRC_ADDR SHALL hold at DEPTH-1 after the last fetch; reads beyond DEPTH-1 are forbidden.
REQ-010 After the last STREAM cycle the FSM SHALL enter GUARD_WAIT for exactly GUARD cycles, then return to IDLE.
REQ-011 Timing: UPDATE sampled at edge n gives first DOUT_VALID in cycle n+2, last in cycle n+1+DEPTH, and IDLE again at n+2+DEPTH+GUARD; minimum UPDATE period is 2+DEPTH+GUARD (259 with defaults).
REQ-012 UPDATE while not IDLE SHALL be ignored, pulse OVERRUN for 1 cycle, and increment OVERRUN_COUNT, which saturates at 16'hFFFF.
REQ-013 INTENSITY/PHASE SHALL hold their last value when DOUT_VALID is low.
REQ-014 CONFIG_VALID in IDLE SHALL update COMPLETION_STEPS_* at the next edge.
REQ-015 CONFIG_VALID outside IDLE SHALL store a pending config (last write wins) and set a pending flag.
REQ-016 A pending config SHALL apply at the first edge in IDLE and clear the flag.
REQ-017 COMPLETION_STEPS_* SHALL never change in FETCH, STREAM or GUARD_WAIT.
REQ-018 Simultaneous UPDATE and CONFIG_VALID in IDLE SHALL apply the new config, and the burst SHALL use it.
REQ-019 Simultaneous UPDATE and a pending config in IDLE SHALL apply the pending config, and the burst SHALL use it.
REQ-020 A requested steps value of 0 SHALL be clamped to 1, so the divisor is never zero.
REQ-021 An illegal state SHALL recover to IDLE on the next edge.

Reset
REQ-022 While RST is high: state=IDLE, SRC_ADDR=0, DOUT_VALID=0, INTENSITY=0, PHASE=0, BUSY=0, OVERRUN=0, OVERRUN_COUNT=0, pending flag cleared, COMPLETION_STEPS_* = DEFAULT_STEPS_*.
REQ-023 RST asserted mid-burst SHALL drop DOUT_VALID immediately (asynchronously) and abandon the burst; the first UPDATE after release SHALL start a full burst at address 0.

Structure
REQ-024 The package silencer_pkg SHALL hold state_t, the divider latency constant (6) and the default step constants.
REQ-025 The pending-config register with clamping SHALL be sub-module step_config_latch; all other logic SHALL be flat.

Verification
REQ-026 Single UPDATE with SRC data = address -> 249 contiguous DOUT_VALID cycles, INTENSITY 0..248, BUSY low exactly 259 cycles after UPDATE.
REQ-027 UPDATE at cycles 0 and 100 -> one burst only, OVERRUN pulse at cycle 100, OVERRUN_COUNT=1; an UPDATE at cycle 259 is accepted.
REQ-028 CONFIG_VALID with steps 20/80 at cycle 50 of a burst -> outputs stay 10/40 through GUARD_WAIT, become 20/80 on the first IDLE edge.
REQ-029 CONFIG_VALID with 0/0 and UPDATE in the same IDLE cycle -> burst runs with COMPLETION_STEPS_* = 1/1.
REQ-030 RST pulse at burst cycle 120 -> DOUT_VALID low at once, all outputs at reset values; the next UPDATE streams addresses 0..248 intact.
REQ-031 70000 overrun UPDATEs -> OVERRUN_COUNT saturates at 65535.

Source files
------------

// File: rtl/silencer_pkg.sv
// Shared types and constants for the silencer step scheduling slice.
// Holds the scheduler state encoding, divider latency and default completion steps.
package silencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        GUARD_WAIT
    } state_t;

    localparam int DIVIDER_LATENCY     = 6;
    localparam int DEF_STEPS_INTENSITY = 10;
    localparam int DEF_STEPS_PHASE     = 40;

    // A zero divisor would stall the step calculator, so zero becomes one.
    function automatic logic [7:0] clamp_steps(input logic [7:0] steps);
        return (steps == 8'd0) ? 8'd1 : steps;
    endfunction

endpackage

// File: rtl/step_config_latch.sv
// Captures completion-step requests that arrive mid-burst and releases them once
// the scheduler is idle; a fresh request seen in idle takes precedence over a pending one.
module step_config_latch
    import silencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       is_idle,
    input  logic       config_valid,
    input  logic [7:0] cfg_intensity,
    input  logic [7:0] cfg_phase,
    output logic       apply,
    output logic [7:0] apply_intensity,
    output logic [7:0] apply_phase
);

    logic       pending;
    logic [7:0] pend_intensity;
    logic [7:0] pend_phase;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending        <= 1'b0;
            pend_intensity <= 8'd1;
            pend_phase     <= 8'd1;
        end else if (is_idle) begin
            pending <= 1'b0;
        end else if (config_valid) begin
            pending        <= 1'b1;
            pend_intensity <= clamp_steps(cfg_intensity);
            pend_phase     <= clamp_steps(cfg_phase);
        end
    end

    always_comb begin
        apply           = is_idle && (config_valid || pending);
        apply_intensity = config_valid ? clamp_steps(cfg_intensity) : pend_intensity;
        apply_phase     = config_valid ? clamp_steps(cfg_phase)     : pend_phase;
    end

endmodule

// File: rtl/step_scheduler.sv
// Streams DEPTH transducer entries from source memory to the step calculator per UPDATE,
// then idles for GUARD cycles so the divider pipeline drains before the next burst.
module step_scheduler
    import silencer_pkg::*;
#(
    parameter int DEPTH                   = 249,
    parameter int GUARD                   = DIVIDER_LATENCY + 2,
    parameter int DEFAULT_STEPS_INTENSITY = DEF_STEPS_INTENSITY,
    parameter int DEFAULT_STEPS_PHASE     = DEF_STEPS_PHASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        UPDATE,
    input  logic        CONFIG_VALID,
    input  logic [7:0]  CONFIG_STEPS_INTENSITY,
    input  logic [7:0]  CONFIG_STEPS_PHASE,
    output logic [7:0]  SRC_ADDR,
    input  logic [7:0]  SRC_INTENSITY,
    input  logic [7:0]  SRC_PHASE,
    output logic        DOUT_VALID,
    output logic [7:0]  INTENSITY,
    output logic [7:0]  PHASE,
    output logic [7:0]  COMPLETION_STEPS_INTENSITY,
    output logic [7:0]  COMPLETION_STEPS_PHASE,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic [15:0] OVERRUN_COUNT
);

    localparam logic [7:0] LAST_ADDR   = 8'(DEPTH - 1);
    localparam logic [8:0] STREAM_LAST = 9'(DEPTH - 1);
    localparam logic [8:0] GUARD_LAST  = 9'(GUARD - 1);

    state_t     state;
    state_t     state_next;
    logic [8:0] cnt;
    logic       is_idle;
    logic       cfg_apply;
    logic [7:0] cfg_intensity;
    logic [7:0] cfg_phase;

    assign is_idle = (state == IDLE);
    assign BUSY    = !is_idle;
    assign OVERRUN = UPDATE && !is_idle;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (UPDATE) state_next = FETCH;
            FETCH:      state_next = STREAM;
            STREAM:     if (cnt == STREAM_LAST) state_next = GUARD_WAIT;
            GUARD_WAIT: if (cnt == GUARD_LAST) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Counter restarts on every state change so it measures time within STREAM and GUARD_WAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= 9'd0;
            SRC_ADDR <= 8'd0;
        end else begin
            if (is_idle || state_next != state) cnt <= 9'd0;
            else                                cnt <= cnt + 9'd1;

            if (is_idle && UPDATE)
                SRC_ADDR <= 8'd0;
            else if ((state == FETCH || state == STREAM) && SRC_ADDR != LAST_ADDR)
                SRC_ADDR <= SRC_ADDR + 8'd1;
        end
    end

    // Source data lags its address by one cycle, so each STREAM cycle sees the previous fetch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DOUT_VALID <= 1'b0;
            INTENSITY  <= 8'd0;
            PHASE      <= 8'd0;
        end else begin
            DOUT_VALID <= (state == STREAM);
            if (state == STREAM) begin
                INTENSITY <= SRC_INTENSITY;
                PHASE     <= SRC_PHASE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERRUN_COUNT <= 16'd0;
        end else if (OVERRUN && OVERRUN_COUNT != 16'hFFFF) begin
            OVERRUN_COUNT <= OVERRUN_COUNT + 16'd1;
        end
    end

    step_config_latch u_config_latch (
        .CLK             (CLK),
        .RST             (RST),
        .is_idle         (is_idle),
        .config_valid    (CONFIG_VALID),
        .cfg_intensity   (CONFIG_STEPS_INTENSITY),
        .cfg_phase       (CONFIG_STEPS_PHASE),
        .apply           (cfg_apply),
        .apply_intensity (cfg_intensity),
        .apply_phase     (cfg_phase)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COMPLETION_STEPS_INTENSITY <= 8'(DEFAULT_STEPS_INTENSITY);
            COMPLETION_STEPS_PHASE     <= 8'(DEFAULT_STEPS_PHASE);
        end else if (cfg_apply) begin
            COMPLETION_STEPS_INTENSITY <= cfg_intensity;
            COMPLETION_STEPS_PHASE     <= cfg_phase;
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler: bursts push expected stream entries, a negedge
// monitor pops them on DOUT_VALID; timing, config and overrun behaviour are checked directly.
module tb_step_scheduler;

    localparam int DEPTH = 249;
    localparam int GUARD = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        UPDATE;
    logic        CONFIG_VALID;
    logic [7:0]  CONFIG_STEPS_INTENSITY;
    logic [7:0]  CONFIG_STEPS_PHASE;
    logic [7:0]  SRC_ADDR;
    logic [7:0]  SRC_INTENSITY;
    logic [7:0]  SRC_PHASE;
    logic        DOUT_VALID;
    logic [7:0]  INTENSITY;
    logic [7:0]  PHASE;
    logic [7:0]  COMPLETION_STEPS_INTENSITY;
    logic [7:0]  COMPLETION_STEPS_PHASE;
    logic        BUSY;
    logic        OVERRUN;
    logic [15:0] OVERRUN_COUNT;

    typedef struct packed {
        logic [7:0] inten;
        logic [7:0] ph;
        logic [7:0] stepsI;
        logic [7:0] stepsP;
    } expect_t;

    expect_t sbQueue[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      sbEnable;
    int      validCount = 0;
    int      riseCyc = 0;
    int      lastValidCyc = 0;

    step_scheduler #(
        .DEPTH (DEPTH),
        .GUARD (GUARD)
    ) dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .UPDATE                     (UPDATE),
        .CONFIG_VALID               (CONFIG_VALID),
        .CONFIG_STEPS_INTENSITY     (CONFIG_STEPS_INTENSITY),
        .CONFIG_STEPS_PHASE         (CONFIG_STEPS_PHASE),
        .SRC_ADDR                   (SRC_ADDR),
        .SRC_INTENSITY              (SRC_INTENSITY),
        .SRC_PHASE                  (SRC_PHASE),
        .DOUT_VALID                 (DOUT_VALID),
        .INTENSITY                  (INTENSITY),
        .PHASE                      (PHASE),
        .COMPLETION_STEPS_INTENSITY (COMPLETION_STEPS_INTENSITY),
        .COMPLETION_STEPS_PHASE     (COMPLETION_STEPS_PHASE),
        .BUSY                       (BUSY),
        .OVERRUN                    (OVERRUN),
        .OVERRUN_COUNT              (OVERRUN_COUNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous source memory: intensity equals address, phase is address xor A5.
    always @(posedge CLK) begin
        SRC_INTENSITY <= SRC_ADDR;
        SRC_PHASE     <= SRC_ADDR ^ 8'hA5;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit upd, input bit cv, input logic [7:0] ci, input logic [7:0] cp);
        UPDATE                 = upd;
        CONFIG_VALID           = cv;
        CONFIG_STEPS_INTENSITY = ci;
        CONFIG_STEPS_PHASE     = cp;
    endtask

    task automatic pushBurst(input logic [7:0] si, input logic [7:0] sp);
        for (int i = 0; i < DEPTH; i++) begin
            sbQueue.push_back({8'(i), 8'(i) ^ 8'hA5, si, sp});
        end
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (BUSY && n < bound) begin
            tick();
            n++;
        end
        if (BUSY) checkOutput("wait_idle_timeout", int'(BUSY), 0);
    endtask

    // Full burst from idle: UPDATE (optionally with config) for one cycle, then timing checks.
    task automatic runBurst(input string tag, input bit cv, input logic [7:0] ci, input logic [7:0] cp,
                            input logic [7:0] si, input logic [7:0] sp);
        int c;
        int v0;
        int n;
        c  = cyc;
        v0 = validCount;
        applyStimulus(1'b1, cv, ci, cp);
        pushBurst(si, sp);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput({tag, "_steps_i"}, int'(COMPLETION_STEPS_INTENSITY), int'(si));
        checkOutput({tag, "_steps_p"}, int'(COMPLETION_STEPS_PHASE), int'(sp));
        n = 1;
        while (BUSY && n < 1000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_busy_cycles"}, n, 2 + DEPTH + GUARD);
        checkOutput({tag, "_valid_count"}, validCount - v0, DEPTH);
        checkOutput({tag, "_first_valid"}, riseCyc, c + 3);
        checkOutput({tag, "_last_valid"}, lastValidCyc, c + 2 + DEPTH);
        checkOutput({tag, "_sb_drained"}, sbQueue.size(), 0);
    endtask

    initial begin
        int c;
        int n;
        RST = 1'b1;
        sbEnable = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);

        fork
            begin : monitor
                expect_t e;
                bit prevValid;
                logic [7:0] heldI;
                logic [7:0] heldP;
                prevValid = 1'b0;
                heldI = 8'd0;
                heldP = 8'd0;
                forever begin
                    @(negedge CLK);
                    if (RST) begin
                        heldI = 8'd0;
                        heldP = 8'd0;
                    end else if (DOUT_VALID) begin
                        validCount++;
                        if (!prevValid) riseCyc = cyc;
                        lastValidCyc = cyc;
                        heldI = INTENSITY;
                        heldP = PHASE;
                        if (sbEnable) begin
                            if (sbQueue.size() == 0) begin
                                checkOutput("sb_unexpected_valid", int'(DOUT_VALID), 0);
                            end else begin
                                e = sbQueue.pop_front();
                                checkOutput("sb_intensity", int'(INTENSITY), int'(e.inten));
                                checkOutput("sb_phase", int'(PHASE), int'(e.ph));
                                checkOutput("sb_steps_i", int'(COMPLETION_STEPS_INTENSITY), int'(e.stepsI));
                                checkOutput("sb_steps_p", int'(COMPLETION_STEPS_PHASE), int'(e.stepsP));
                            end
                        end
                    end else begin
                        checkOutput("hold_intensity", int'(INTENSITY), int'(heldI));
                        checkOutput("hold_phase", int'(PHASE), int'(heldP));
                    end
                    checkOutput("src_addr_range", int'(SRC_ADDR <= 8'(DEPTH - 1)), 1);
                    prevValid = DOUT_VALID;
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        checkOutput("rst_dout_valid", int'(DOUT_VALID), 0);
        checkOutput("rst_src_addr", int'(SRC_ADDR), 0);
        checkOutput("rst_intensity", int'(INTENSITY), 0);
        checkOutput("rst_phase", int'(PHASE), 0);
        checkOutput("rst_busy", int'(BUSY), 0);
        checkOutput("rst_overrun", int'(OVERRUN), 0);
        checkOutput("rst_overrun_count", int'(OVERRUN_COUNT), 0);
        checkOutput("rst_steps_i", int'(COMPLETION_STEPS_INTENSITY), 10);
        checkOutput("rst_steps_p", int'(COMPLETION_STEPS_PHASE), 40);
        RST = 1'b0;
        tick();

        // Single burst with default steps
        runBurst("burst1", 1'b0, 8'd0, 8'd0, 8'd10, 8'd40);

        // UPDATE at cycles 0, 100 and 259
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        pushBurst(8'd10, 8'd40);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        while (cyc < c + 100) tick();
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        #1;
        checkOutput("overrun_pulse", int'(OVERRUN), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("overrun_count_one", int'(OVERRUN_COUNT), 1);
        #1;
        checkOutput("overrun_pulse_end", int'(OVERRUN), 0);
        while (cyc < c + 259) tick();
        checkOutput("idle_at_259", int'(BUSY), 0);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        pushBurst(8'd10, 8'd40);
        #1;
        checkOutput("no_overrun_at_259", int'(OVERRUN), 0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("accepted_at_259", int'(BUSY), 1);
        checkOutput("overrun_count_still_one", int'(OVERRUN_COUNT), 1);
        waitIdle(400);
        checkOutput("overrun_sb_drained", sbQueue.size(), 0);

        // Config 20/80 mid-burst stays pending until the first idle edge
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        pushBurst(8'd10, 8'd40);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        while (cyc < c + 50) tick();
        applyStimulus(1'b0, 1'b1, 8'd20, 8'd80);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        n = 0;
        while (BUSY && n < 400) begin
            checkOutput("pending_hold_i", int'(COMPLETION_STEPS_INTENSITY), 10);
            checkOutput("pending_hold_p", int'(COMPLETION_STEPS_PHASE), 40);
            tick();
            n++;
        end
        checkOutput("pending_first_idle_i", int'(COMPLETION_STEPS_INTENSITY), 10);
        tick();
        checkOutput("pending_applied_i", int'(COMPLETION_STEPS_INTENSITY), 20);
        checkOutput("pending_applied_p", int'(COMPLETION_STEPS_PHASE), 80);
        checkOutput("pending_sb_drained", sbQueue.size(), 0);

        // Zero steps with UPDATE in the same idle cycle are clamped to one
        runBurst("clamp", 1'b1, 8'd0, 8'd0, 8'd1, 8'd1);

        // Pending config (last write wins) applied together with UPDATE on the first idle edge
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        pushBurst(8'd1, 8'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        while (cyc < c + 100) tick();
        applyStimulus(1'b0, 1'b1, 8'd50, 8'd50);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        while (cyc < c + 120) tick();
        applyStimulus(1'b0, 1'b1, 8'd30, 8'd60);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        waitIdle(400);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        pushBurst(8'd30, 8'd60);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("pending_update_busy", int'(BUSY), 1);
        checkOutput("pending_update_i", int'(COMPLETION_STEPS_INTENSITY), 30);
        checkOutput("pending_update_p", int'(COMPLETION_STEPS_PHASE), 60);
        waitIdle(400);
        checkOutput("pending_update_sb_drained", sbQueue.size(), 0);

        // Reset at burst cycle 120 abandons the burst immediately
        sbEnable = 1'b0;
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        while (cyc < c + 120) tick();
        checkOutput("midburst_valid", int'(DOUT_VALID), 1);
        RST = 1'b1;
        #1;
        checkOutput("async_rst_dout_valid", int'(DOUT_VALID), 0);
        checkOutput("async_rst_busy", int'(BUSY), 0);
        checkOutput("async_rst_src_addr", int'(SRC_ADDR), 0);
        checkOutput("async_rst_intensity", int'(INTENSITY), 0);
        checkOutput("async_rst_phase", int'(PHASE), 0);
        checkOutput("async_rst_overrun_count", int'(OVERRUN_COUNT), 0);
        checkOutput("async_rst_steps_i", int'(COMPLETION_STEPS_INTENSITY), 10);
        checkOutput("async_rst_steps_p", int'(COMPLETION_STEPS_PHASE), 40);
        tick();
        RST = 1'b0;
        tick();
        sbEnable = 1'b1;
        runBurst("after_rst", 1'b0, 8'd0, 8'd0, 8'd10, 8'd40);

        // UPDATE held high: one burst accepted every 259 edges, the rest counted until saturation
        sbEnable = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        repeat (777) tick();
        checkOutput("overrun_count_777", int'(OVERRUN_COUNT), 774);
        repeat (70000 - 777) tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("overrun_saturated", int'(OVERRUN_COUNT), 65535);
        waitIdle(400);
        checkOutput("overrun_saturated_held", int'(OVERRUN_COUNT), 65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
